sub_bytes_engine: RTL and testbench
===================================

# sub_bytes_engine

Parametrised, sequential AES SubBytes engine. It accepts a 128-bit state over a valid/ready handshake and substitutes it LANES bytes per cycle through a bank of S-box lanes. It returns the result over a second valid/ready handshake. It sits between the round-key/ShiftRows stages of the round datapath and trades area (LANES S-boxes instead of 16) against latency, with optional inverse substitution for decryption.

## Interface
- LANES, 4, S-box lanes per cycle; legal values 1, 2, 4, 8, 16 (must divide 16); elaboration error otherwise.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state (and in_inv) presented.
- in_ready  output  1  engine can accept a block this cycle.
- in_state  input  128  input state; byte 0 = [127:120], byte 15 = [7:0].
- in_inv  input  1  1 = inverse S-box; present only with SUB_BYTES_INV_EN.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  substituted state, same byte order as input.
- busy  output  1  high in SUB state.

## Operation
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into the working register, capture in_inv into the mode register, clear cnt, go to SUB.
- SUB:
  - Each cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 (byte 0 first) with their S-box images; leave all other bytes unchanged.
  - cnt is a $clog2(16/LANES)-bit counter (1 bit minimum).
  - On the cycle with cnt==16/LANES-1, go to DONE.
- DONE:
  - out_valid=1; out_state is held stable until out_valid&&out_ready.
  - On that handshake, in_ready=1 in the same cycle (combinational: in_ready = IDLE || (DONE && out_ready)).
  - If in_valid is also high, capture the new block and go directly to SUB; otherwise go to IDLE.
- out_state is the working register. It is valid only while out_valid=1; during SUB it shows partial data and is not checked.
- in_valid is ignored in SUB and in DONE while out_ready=0. The producer holds its data; no drop, no overwrite.
- Mode is fixed per block; in_inv changes mid-block have no effect.

## Timing
- Reset values: out_valid=0, out_state=0, busy=0, FSM=IDLE, cnt=0, mode=0. in_ready is forced to 0 while rst=1.
- Latency: block accepted at edge N → out_valid high after edge N+16/LANES (LANES=16: 1 cycle; LANES=1: 16 cycles).
- Throughput with out_ready tied high: one block per 16/LANES+1 cycles.
- Reset asserted mid-SUB or in DONE: block discarded, no out_valid pulse, outputs return to reset values immediately.
- All outputs are registered except in_ready, which is decoded from FSM state and out_ready.

## Configuration
- SUB_BYTES_INV_EN defined:
  - in_inv port exists.
  - Each lane selects the forward or inverse S-box from the mode register.
- SUB_BYTES_INV_EN undefined:
  - in_inv port and mode register are removed.
  - Lanes implement forward S-box only.
  - Behaviour is otherwise identical.

## Structure
- Package sub_bytes_pkg contains:
  - SBOX and INV_SBOX as 256×8 constant arrays.
  - The FSM state enum.
  - A function sbox_f(byte, inv).
- Sub-module sbox_lane: combinational 8-bit lookup with inv select, instantiated LANES times by a generate loop.
- The lane input mux picks bytes by cnt; the write-back is a byte-enable on the working register.

## Test plan
- Forward, LANES=4: in_state=00010203_04050607_08090a0b_0c0d0e0f → out_state=637c777b_f26b6fc5_3001672b_fed7ab76; out_valid exactly 4 cycles after acceptance.
- Inverse (SUB_BYTES_INV_EN), LANES=4: in_state=637c777b_f26b6fc5_3001672b_fed7ab76, in_inv=1 → out_state=00010203_04050607_08090a0b_0c0d0e0f.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_state stable, in_ready=0, a second in_valid is not accepted. Then raise out_ready with in_valid high → back-to-back acceptance, second result 4 cycles later.
- Latency sweep, LANES ∈ {1, 2, 8, 16}: all-0x53 state → all-0xED; out_valid at 16, 8, 2, 1 cycles.
- Reset mid-operation: assert rst 2 cycles into SUB → out_valid never pulses, out_state=0. After release, a new block completes correctly.
- Random: 1000 blocks with random valid/ready stalls, checked against a scoreboard using sbox_f; no lost or duplicated blocks.

Source files
------------

// File: rtl/sub_bytes_pkg.sv
// sub_bytes_pkg: AES S-box tables, FSM state type and lookup helper
// shared by the SubBytes engine and its lanes.
package sub_bytes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox_f(input logic [7:0] b, input logic inv);
      return inv ? INV_SBOX[b] : SBOX[b];
   endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// sub_bytes_engine_if: input and output valid/ready channels of the SubBytes engine.
// in_inv exists only when SUB_BYTES_INV_EN is defined.
interface sub_bytes_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
`ifdef SUB_BYTES_INV_EN
   logic         in_inv;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
`ifdef SUB_BYTES_INV_EN
      output in_inv,
`endif
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
`ifdef SUB_BYTES_INV_EN
      input  in_inv,
`endif
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface

// File: rtl/sbox_lane.sv
// sbox_lane: one combinational AES S-box byte lookup, forward or inverse.
module sbox_lane
   import sub_bytes_pkg::*;
(
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);

   // Table lookup; inv selects the decryption table
   always_comb begin
      dout = sbox_f(din, inv);
   end

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: sequential AES SubBytes, LANES bytes substituted per cycle.
// Optional feature macro: SUB_BYTES_INV_EN adds in_inv and per-block inverse substitution.
module sub_bytes_engine
   import sub_bytes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic              clk,
   input  logic              rst,
   sub_bytes_engine_if.slave bus,
   output logic              busy
);

   localparam int STEPS = 16 / LANES;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [127:0]  work;
   logic          lane_inv;
   logic          in_ready;
   logic          accept;
   logic          out_valid_q;
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    lane_out [LANES];

`ifdef SUB_BYTES_INV_EN
   logic mode;
   assign lane_inv = mode;
`else
   assign lane_inv = 1'b0;
`endif

   // Lane g sees byte cnt*LANES+g of the working register (byte 0 in the top bits)
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_in[g] = work[8*(15 - (int'(cnt)*LANES + g)) +: 8];
      sbox_lane u_lane (
         .din  (lane_in[g]),
         .inv  (lane_inv),
         .dout (lane_out[g])
      );
   end

   // in_ready is decoded so a finished block can hand over to the next in one cycle
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
      end
   end

   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = work;

   // Next-state decode: accept, step through the byte groups, then hold until drained
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) state_nx = SUB;
         end
         SUB: begin
            if (cnt == LAST_CNT) state_nx = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_nx = bus.in_valid ? SUB : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Working register: load on accept, byte-enabled write-back of the active group during SUB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work        <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
`ifdef SUB_BYTES_INV_EN
         mode        <= 1'b0;
`endif
      end else begin
         out_valid_q <= (state_nx == DONE);
         busy        <= (state_nx == SUB);
         if (accept) begin
            work <= bus.in_state;
            cnt  <= '0;
`ifdef SUB_BYTES_INV_EN
            mode <= bus.in_inv;
`endif
         end else if (state == SUB) begin
            for (int b = 0; b < 16; b++) begin
               if (CW'(b / LANES) == cnt) work[8*(15 - b) +: 8] <= lane_out[b % LANES];
            end
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: self-checking bench for sub_bytes_engine.
// The reference S-box is derived from GF(2^8) inversion plus the AES affine map.
// Define SUB_BYTES_INV_EN to also cover inverse substitution.
module tb_sub_bytes_engine;

   localparam int LANES = 4;
   localparam int STEPS = 16 / LANES;

   localparam logic [127:0] VEC_PLAIN = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] VEC_SUBST = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
   localparam logic [127:0] VEC_53    = {16{8'h53}};
   localparam logic [127:0] VEC_ED    = {16{8'hed}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic tb_inv = 1'b0;
   logic random_mode = 1'b0;
   logic sweep_go = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_in = 0;
   int n_out = 0;

   logic [127:0] exp_q [$];
   logic [7:0]   model_fwd [256];
   logic [7:0]   model_inv [256];

   sub_bytes_engine_if bus ();
`ifdef SUB_BYTES_INV_EN
   assign bus.in_inv = tb_inv;
`endif

   sub_bytes_engine #(.LANES(LANES)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      logic       hi;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         hi = x[7];
         x  = {x[6:0], 1'b0};
         if (hi) x = x ^ 8'h1b;
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic buildModel();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         model_fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) model_inv[model_fwd[x]] = 8'(x);
   endtask

   function automatic logic [127:0] modelBlock(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         b = s[8*(15 - i) +: 8];
         r[8*(15 - i) +: 8] = inv ? model_inv[b] : model_fwd[b];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got timeout expected handshake", name);
   endtask

   // Scoreboard: every accepted block is modelled, every cycle out_valid is high is checked
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_out_valid", {127'b0, bus.out_valid}, 128'd0);
            end else begin
               checkOutput("scoreboard_out_state", bus.out_state, exp_q[0]);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(modelBlock(bus.in_state, tb_inv));
            n_in++;
         end
      end
   end

   // Random consumer backpressure, active only during the random phase
   always @(posedge clk) begin
      #2;
      if (random_mode) bus.out_ready = 1'($urandom_range(0, 1));
   end

   // Latency sweep instances, one per alternative lane count
   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int LV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      sub_bytes_engine_if sw ();
      logic         sw_busy;
      logic         done = 1'b0;
      int           lat = -1;
      logic [127:0] data = '0;
`ifdef SUB_BYTES_INV_EN
      assign sw.in_inv = 1'b0;
`endif
      sub_bytes_engine #(.LANES(LV)) u_dut (
         .clk  (clk),
         .rst  (rst),
         .bus  (sw.slave),
         .busy (sw_busy)
      );
      initial begin
         int t;
         sw.in_valid  = 1'b0;
         sw.in_state  = '0;
         sw.out_ready = 1'b0;
         wait (sweep_go);
         @(posedge clk); #1;
         sw.in_valid = 1'b1;
         sw.in_state = VEC_53;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!sw.in_ready && t < 100);
         @(posedge clk); #1;
         sw.in_valid = 1'b0;
         lat = 0;
         while (!sw.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
         end
         data = sw.out_state;
         sw.out_ready = 1'b1;
         done = 1'b1;
      end
   end

   task automatic sendBlock(input logic [127:0] data, input logic inv, output bit ok);
      int t;
      t  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_state = data;
      tb_inv = inv;
      while (!ok && t < 200) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk); #1;
         t++;
      end
      bus.in_valid = 1'b0;
      if (!ok) timeoutFail("accept");
   endtask

   task automatic waitOutValid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) timeoutFail("out_valid");
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic applyStimulus(input string name, input logic [127:0] data, input logic inv,
                                input logic [127:0] expected);
      bit ok;
      int lat;
      sendBlock(data, inv, ok);
      checkOutput({name, "_busy"}, {127'b0, busy}, 128'd1);
      waitOutValid(lat);
      checkOutput({name, "_latency"}, 128'(lat), 128'(STEPS));
      checkOutput({name, "_out_state"}, bus.out_state, expected);
      drain();
   endtask

   // Watchdog so the bench always ends
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      int lat;
      int t;
      int base_in;
      int base_out;
      logic [127:0] data;
      logic inv;

      bus.in_valid  = 1'b0;
      bus.in_state  = '0;
      bus.out_ready = 1'b0;

      buildModel();
      checkOutput("model_fwd_00", 128'(model_fwd[8'h00]), 128'h63);
      checkOutput("model_fwd_53", 128'(model_fwd[8'h53]), 128'hed);
      checkOutput("model_inv_ed", 128'(model_inv[8'hed]), 128'h53);
      checkOutput("model_block_fwd", modelBlock(VEC_PLAIN, 1'b0), VEC_SUBST);

      // Reset state
      #3;
      checkOutput("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      checkOutput("rst_out_state", bus.out_state, 128'd0);
      checkOutput("rst_busy", {127'b0, busy}, 128'd0);
      checkOutput("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_in_ready", {127'b0, bus.in_ready}, 128'd1);

      $display("[TB] forward substitution");
      applyStimulus("fwd", VEC_PLAIN, 1'b0, VEC_SUBST);

`ifdef SUB_BYTES_INV_EN
      $display("[TB] inverse substitution");
      applyStimulus("inv", VEC_SUBST, 1'b1, VEC_PLAIN);
`endif

      $display("[TB] backpressure");
      sendBlock(VEC_PLAIN, 1'b0, ok);
      waitOutValid(lat);
      bus.in_valid = 1'b1;
      bus.in_state = VEC_53;
      tb_inv = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready", {127'b0, bus.in_ready}, 128'd0);
         checkOutput("bp_hold", bus.out_state, VEC_SUBST);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_in_ready_release", {127'b0, bus.in_ready}, 128'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      waitOutValid(lat);
      checkOutput("bp_b2b_latency", 128'(lat), 128'(STEPS));
      checkOutput("bp_second", bus.out_state, VEC_ED);
      drain();

      $display("[TB] reset during SUB");
      sendBlock(VEC_PLAIN, 1'b0, ok);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      checkOutput("midrst_out_state", bus.out_state, 128'd0);
      checkOutput("midrst_busy", {127'b0, busy}, 128'd0);
      checkOutput("midrst_in_ready", {127'b0, bus.in_ready}, 128'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("postrst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      applyStimulus("postrst", VEC_53, 1'b0, VEC_ED);

      $display("[TB] latency sweep");
      sweep_go = 1'b1;
      t = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) && t < 300) begin
         @(posedge clk);
         t++;
      end
      #1;
      checkOutput("sweep_lat_L1", 128'(g_sweep[0].lat), 128'd16);
      checkOutput("sweep_lat_L2", 128'(g_sweep[1].lat), 128'd8);
      checkOutput("sweep_lat_L8", 128'(g_sweep[2].lat), 128'd2);
      checkOutput("sweep_lat_L16", 128'(g_sweep[3].lat), 128'd1);
      checkOutput("sweep_data_L1", g_sweep[0].data, VEC_ED);
      checkOutput("sweep_data_L2", g_sweep[1].data, VEC_ED);
      checkOutput("sweep_data_L8", g_sweep[2].data, VEC_ED);
      checkOutput("sweep_data_L16", g_sweep[3].data, VEC_ED);

      $display("[TB] random traffic");
      @(posedge clk); #1;
      base_in  = n_in;
      base_out = n_out;
      random_mode = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         data = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUB_BYTES_INV_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         sendBlock(data, inv, ok);
      end
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      random_mode = 1'b0;
      bus.out_ready = 1'b0;
      checkOutput("random_accepted", 128'(n_in - base_in), 128'd1000);
      checkOutput("random_delivered", 128'(n_out - base_out), 128'd1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
